dm_subword_mem: RTL
===================

// Module: dm_subword_mem
// PURPOSE
//  Parametrised data memory for the pipelined MIPS MEM stage with byte-lane stores, sign/zero-extended
//  sub-word loads, misalignment detection, a configurable read-latency pipeline and a pipeline stall.
//  Sits between the EX/MEM register and MEM/WB. One request per cycle; responses return in order.
// PARAMETERS
//  DEPTH_WORDS  1024      number of 32-bit words; power of two; AW = $clog2(DEPTH_WORDS)
//  BASE_ADDR    32'h0     byte address of word 0; must be a multiple of 4*DEPTH_WORDS
//  RD_LAT       1         cycles from accept edge to rsp_valid; legal range 1..4
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst_n         in   1   asynchronous active-low reset
//  stall         in   1   freezes the whole block: no accept, latency pipeline and rsp_* hold
//  req_valid     in   1   request present
//  req_ready     out  1   = ~stall (combinational)
//  req_we        in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word; 11 reserved (flagged as error)
//  req_unsigned  in   1   loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend (lb/lh)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid     out  1   response for request accepted RD_LAT unstalled cycles earlier
//  rsp_rdata     out  32  extended load data; 0 for stores and errored requests
//  rsp_err       out  1   request was misaligned, reserved size or out of range
// BEHAVIOUR
//  - Accept = req_valid & req_ready at posedge. Exactly one response per accepted request, stores included.
//  - Little-endian: byte at addr[1:0]=k occupies bits [8k+7:8k] of the word.
//  - Index = (req_addr - BASE_ADDR)[AW+1:2]. Byte offset = req_addr[1:0].
//  - Errors: half with addr[0]=1; word with addr[1:0]!=0; size 11; out of range (see CONFIGURATION).
//    An errored store writes nothing. An errored load returns rdata 0, rsp_err=1.
//  - Store: committed at the accept edge, only the addressed lanes (be = 0001<<k, 0011<<k, 1111).
//    Data is replicated to the lanes (byte x4, half x2) before masking.
//  - Load: memory word read at the accept edge into stage 1. Offset, size, unsigned, err and valid
//    travel down an RD_LAT-deep shift register. Lane select and extension happen in the final stage:
//    rsp_rdata = ext(word >> 8k, size, unsigned).
//  - A load accepted the cycle after a store to the same word sees the stored data.
//    Only one request exists per cycle, so there is no same-cycle read/write collision.
//  - stall=1: no accept, no memory write, all pipeline stages and rsp_* hold their values. A rsp_valid
//    held across a stall is the same single response; the consumer samples it on the first unstalled edge.
//  - Unstalled cycle with no accept: a bubble (valid=0) enters stage 1.
//  - Reset (async assert, sync deassert by the system): rsp_valid=0, rsp_rdata=0, rsp_err=0, all stage
//    valid bits and payloads cleared. In-flight responses are discarded, never delivered after reset.
//    Memory contents are not reset. A store whose accept edge preceded reset remains committed.
//  - Synthesis/elaboration error if RD_LAT is outside 1..4 or DEPTH_WORDS is not a power of two.
// CONFIGURATION
//  DM_BOUNDS_CHK_EN defined: (req_addr - BASE_ADDR) >= 4*DEPTH_WORDS is an error; no write, rsp_err=1.
//  Undefined: no range check; the index is the low AW bits of the word address and wraps modulo
//  DEPTH_WORDS. Alignment and size errors are checked in both builds.
// TESTING (DEPTH_WORDS=1024, BASE_ADDR=0, RD_LAT=1 unless noted)
//  1. sw 0x11223344 @0x10; lw @0x10 -> rsp_valid 1 cycle after the lw accept, rdata 0x11223344, err 0.
//  2. then sb 0x1A5 @0x13 -> lb @0x13 = 0xFFFFFFA5; lbu @0x13 = 0x000000A5; lw @0x10 = 0xA5223344.
//  3. sh 0x8001 @0x12 -> lh @0x12 = 0xFFFF8001; lhu = 0x00008001; lw @0x10 = 0x80013344.
//  4. lh @0x11 and sw @0x12 -> each rsp_err=1, rdata 0; lw @0x10 still 0x80013344. sw @0x1000:
//     DM_BOUNDS_CHK_EN -> err=1, word 0 unchanged; undefined -> err=0, lw @0x0 returns the stored value.
//  5. RD_LAT=3: lw accepted at cycle 0, stall=1 in cycles 1-2 -> rsp_valid first at cycle 5, held while stalled.
//     Back-to-back loads return in order at one per cycle.
//  6. rst_n low for 1 cycle while two loads are in flight -> rsp_valid stays 0 until a new accept.
//     Memory retains its contents.

Source files
------------

// File: rtl/dm_subword_mem.sv
// Data memory for the MIPS MEM stage: byte-lane stores, sub-word sign/zero-extended loads, RD_LAT-deep response pipe.
// Build option: define DM_BOUNDS_CHK_EN to flag addresses beyond the array as errors instead of wrapping.
module dm_subword_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("dm_subword_mem: RD_LAT must be in 1..4");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("dm_subword_mem: DEPTH_WORDS must be a power of two");
    end
  endgenerate

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    k;
  logic          accept, size_err, align_err, range_err, req_err, wr_en, rd_ok;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req_ready = ~stall;
  assign accept    = req_valid & ~stall;
  assign off       = req_addr - BASE_ADDR;
  assign idx       = off[AW+1:2];
  assign k         = off[1:0];
  assign size_err  = (req_size == 2'b11);
  assign align_err = ((req_size == 2'b01) & k[0]) | ((req_size == 2'b10) & (k != 2'b00));

`ifdef DM_BOUNDS_CHK_EN
  assign range_err = |off[31:AW+2];
`else
  // Without the range check the word index simply wraps, so the high offset bits are don't-care.
  logic unused_off_hi;
  assign unused_off_hi = ^off[31:AW+2];
  assign range_err     = 1'b0;
`endif

  assign req_err = size_err | align_err | range_err;
  assign wr_en   = accept & req_we & ~req_err;
  assign rd_ok   = ~req_we & ~req_err;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        be        = 4'b0001 << k;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << k;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      logic        vld_q, err_q, ok_q, uns_q;
      logic [1:0]  size_q, off_q;
      logic [31:0] word_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            ok_q   <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= 2'b00;
            off_q  <= 2'b00;
          end else if (!stall) begin
            vld_q  <= accept;
            err_q  <= accept & req_err;
            ok_q   <= accept & rd_ok;
            uns_q  <= req_unsigned;
            size_q <= req_size;
            off_q  <= k;
          end
        end
        // Plain registered read keeps the array mappable to block RAM; ok_q masks any stale word.
        always_ff @(posedge clk) begin
          if (accept) word_q <= mem[idx];
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            ok_q   <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= 2'b00;
            off_q  <= 2'b00;
            word_q <= 32'h0;
          end else if (!stall) begin
            vld_q  <= g_stage[gi-1].vld_q;
            err_q  <= g_stage[gi-1].err_q;
            ok_q   <= g_stage[gi-1].ok_q;
            uns_q  <= g_stage[gi-1].uns_q;
            size_q <= g_stage[gi-1].size_q;
            off_q  <= g_stage[gi-1].off_q;
            word_q <= g_stage[gi-1].word_q;
          end
        end
      end
    end
  endgenerate

  logic [31:0] lane_word, ext_data;
  logic        last_uns;

  assign lane_word = g_stage[RD_LAT-1].word_q >> {g_stage[RD_LAT-1].off_q, 3'b000};
  assign last_uns  = g_stage[RD_LAT-1].uns_q;

  always_comb begin
    ext_data = 32'h0;
    case (g_stage[RD_LAT-1].size_q)
      2'b00:   ext_data = {{24{~last_uns & lane_word[7]}}, lane_word[7:0]};
      2'b01:   ext_data = {{16{~last_uns & lane_word[15]}}, lane_word[15:0]};
      2'b10:   ext_data = lane_word;
      default: ext_data = 32'h0;
    endcase
  end

  assign rsp_valid = g_stage[RD_LAT-1].vld_q;
  assign rsp_err   = g_stage[RD_LAT-1].err_q;
  assign rsp_rdata = g_stage[RD_LAT-1].ok_q ? ext_data : 32'h0;
endmodule
